// File: rtl/ps2_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_pkg : shared PS/2 state encodings, frame size, command bytes   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_RESET   = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INHIBIT = 3'd1,
        S_REQ     = 3'd2,
        S_SHIFT   = 3'd3,
        S_PAR     = 3'd4,
        S_STOP    = 3'd5,
        S_ACK_OK  = 3'd6,
        S_ACK_BAD = 3'd7
    } ps2_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_tx_if : command-byte handshake between a host and the     |
// | PS/2 transmitter.  Rev 1.0                                         |
// +--------------------------------------------------------------------+
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, tx_err, busy
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, tx_err, busy
    );
endinterface
`default_nettype wire

// File: rtl/ps2_host_tx_line_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_line_sync : 2-FF synchronisers on PS/2 clock and data plus a   |
// | falling-edge detect on the clock.  Rev 1.0                         |
// +--------------------------------------------------------------------+
module ps2_line_sync (
    input  wire logic clk,
    input  wire logic resetn,
    input  wire logic clk_pin,
    input  wire logic data_pin,
    output logic      clk_s,
    output logic      data_s,
    output logic      fall
);

    logic [1:0] clk_ff;
    logic [1:0] data_ff;
    logic       clk_prev;

    // Idle PS/2 lines float high, so reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_ff   <= 2'b11;
            data_ff  <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_ff   <= {clk_ff[0], clk_pin};
            data_ff  <= {data_ff[0], data_pin};
            clk_prev <= clk_ff[1];
        end
    end

    assign clk_s  = clk_ff[1];
    assign data_s = data_ff[1];
    assign fall   = clk_prev & ~clk_ff[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ps2_host_tx : host-to-device PS/2 command transmitter with ACK.    |
// | Optional watchdog: define PS2_TX_TIMEOUT_EN.   Rev 1.0             |
// +--------------------------------------------------------------------+
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000
`ifdef PS2_TX_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  wire logic     clk,
    input  wire logic     resetn,
    ps2_host_tx_if.slave  tx,
    input  wire logic     ps2_clk_i,
    input  wire logic     ps2_data_i,
    output logic          ps2_clk_oe,
    output logic          ps2_data_oe
);

    localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);

    ps2_tx_state_e    state, state_n;
    logic [INH_W-1:0] inh_cnt, inh_n;
    logic [2:0]       bit_cnt, bit_n;
    logic [7:0]       shreg, sh_n;
    logic             par, par_n;
    logic             data_q, dq_n;
    logic             done_pulse, err_pulse;
    logic             clk_s, data_s, fall;
    logic             inh_last;
    logic             timeout_hit;

    ps2_line_sync u_sync (
        .clk      (clk),
        .resetn   (resetn),
        .clk_pin  (ps2_clk_i),
        .data_pin (ps2_data_i),
        .clk_s    (clk_s),
        .data_s   (data_s),
        .fall     (fall)
    );

    assign inh_last = (inh_cnt == INH_LAST);

`ifdef PS2_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            in_dev_phase;

    assign in_dev_phase = (state != S_IDLE) && (state != S_INHIBIT);
    assign timeout_hit  = in_dev_phase && (wd_cnt == WD_W'(TIMEOUT_CYCLES));

    // Cleared outside device-clocked phases, so REQ entry starts from zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            wd_cnt <= '0;
        else if (!in_dev_phase || fall)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            inh_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            data_q  <= 1'b0;
        end else begin
            state   <= state_n;
            inh_cnt <= inh_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            par     <= par_n;
            data_q  <= dq_n;
        end
    end

    always_comb begin
        state_n    = state;
        inh_n      = inh_cnt;
        bit_n      = bit_cnt;
        sh_n       = shreg;
        par_n      = par;
        dq_n       = data_q;
        done_pulse = 1'b0;
        err_pulse  = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx.tx_valid) begin
                    state_n = S_INHIBIT;
                    sh_n    = tx.tx_data;
                    par_n   = ~^tx.tx_data;
                    bit_n   = '0;
                    inh_n   = '0;
                    dq_n    = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (inh_last) begin
                    state_n = S_REQ;
                    dq_n    = 1'b1;
                end else begin
                    inh_n = inh_cnt + 1'b1;
                end
            end
            S_REQ: begin
                if (fall) begin
                    dq_n    = ~shreg[0];
                    state_n = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (fall) begin
                    if (bit_cnt == 3'd7) begin
                        dq_n    = ~par;
                        state_n = S_PAR;
                    end else begin
                        sh_n  = {1'b0, shreg[7:1]};
                        dq_n  = ~shreg[1];
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (fall) begin
                    dq_n    = 1'b0;
                    state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (fall)
                    state_n = data_s ? S_ACK_BAD : S_ACK_OK;
            end
            S_ACK_OK: begin
                if (clk_s && data_s) begin
                    done_pulse = 1'b1;
                    state_n    = S_IDLE;
                end
            end
            S_ACK_BAD: begin
                if (clk_s && data_s) begin
                    err_pulse = 1'b1;
                    state_n   = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (timeout_hit) begin
            done_pulse = 1'b0;
            err_pulse  = 1'b1;
            dq_n       = 1'b0;
            state_n    = S_IDLE;
        end
    end

    // Data pull-low starts in the last inhibit cycle and then follows data_q.
    assign ps2_data_oe = data_q | ((state == S_INHIBIT) && inh_last);
    assign ps2_clk_oe  = (state == S_INHIBIT);
    assign tx.tx_ready = (state == S_IDLE);
    assign tx.busy     = (state != S_IDLE);
    assign tx.tx_done  = done_pulse;
    assign tx.tx_err   = err_pulse;

endmodule
`default_nettype wire
